// File: rtl/mem_wb_skid_stage.sv
// MEM->WB stage register with valid/ready handshake, 2-entry skid buffer and writeback data select.
// Optional parity protection of the held entries is enabled by defining MEM_WB_PARITY_EN.
module mem_wb_skid_stage #(
   parameter int DATA_W     = 32,
   parameter int REG_ADDR_W = 5
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  flush,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic                  in_wb_en,
   input  logic                  in_mem_r_en,
   input  logic [DATA_W-1:0]     in_alu_res,
   input  logic [DATA_W-1:0]     in_mem_data,
   input  logic [REG_ADDR_W-1:0] in_dest,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic                  out_wb_en,
   output logic [REG_ADDR_W-1:0] out_dest,
   output logic [DATA_W-1:0]     out_wb_data,
   output logic                  fwd_valid,
   output logic                  perr
);

   localparam logic [1:0] EMPTY = 2'd0;
   localparam logic [1:0] FULL  = 2'd1;
   localparam logic [1:0] SKID  = 2'd2;

   typedef struct packed {
      logic                  wb_en;
      logic                  mem_r_en;
      logic [DATA_W-1:0]     alu_res;
      logic [DATA_W-1:0]     mem_data;
      logic [REG_ADDR_W-1:0] dest;
`ifdef MEM_WB_PARITY_EN
      logic                  par;
`endif
   } wb_ent_t;

   logic [1:0] state;
   wb_ent_t    m_q, s_q, in_ent;
   logic       push, pop;

   always_comb begin
      in_ent          = '0;
      in_ent.wb_en    = in_wb_en;
      in_ent.mem_r_en = in_mem_r_en;
      in_ent.alu_res  = in_alu_res;
      in_ent.mem_data = in_mem_data;
      in_ent.dest     = in_dest;
`ifdef MEM_WB_PARITY_EN
      // even parity: the stored bit makes the XOR over all fields plus parity zero
      in_ent.par      = ^{in_wb_en, in_mem_r_en, in_alu_res, in_mem_data, in_dest};
`endif
   end

   // in_ready comes from registered state only, so no comb path from out_ready to in_ready
   assign in_ready  = (state != SKID);
   assign out_valid = (state != EMPTY);
   assign push      = in_valid & in_ready;
   assign pop       = out_valid & out_ready;

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= EMPTY;
         m_q   <= '0;
         s_q   <= '0;
      end else if (flush) begin
         state <= EMPTY;
      end else begin
         case (state)
            EMPTY: if (push) begin
               m_q   <= in_ent;
               state <= FULL;
            end
            FULL: begin
               if (push && pop) begin
                  m_q <= in_ent;
               end else if (push) begin
                  s_q   <= in_ent;
                  state <= SKID;
               end else if (pop) begin
                  state <= EMPTY;
               end
            end
            SKID: if (pop) begin
               m_q   <= s_q;
               state <= FULL;
            end
            default: state <= EMPTY;
         endcase
      end
   end

   assign out_dest    = m_q.dest;
   assign out_wb_data = m_q.mem_r_en ? m_q.mem_data : m_q.alu_res;
   assign out_wb_en   = out_valid & m_q.wb_en & (m_q.dest != '0);
   assign fwd_valid   = out_wb_en;

`ifdef MEM_WB_PARITY_EN
   logic perr_q;
   logic par_bad;

   assign par_bad = ^{m_q.wb_en, m_q.mem_r_en, m_q.alu_res, m_q.mem_data, m_q.dest, m_q.par};

   // sticky until reset; data is not gated on error
   always_ff @(posedge clk) begin
      if (rst)                        perr_q <= 1'b0;
      else if (out_valid && par_bad)  perr_q <= 1'b1;
   end

   assign perr = perr_q;
`else
   assign perr = 1'b0;
`endif

endmodule

// File: tb/tb_mem_wb_skid_stage.sv
// Directed bench for mem_wb_skid_stage: reset, streaming, skid backpressure, load select,
// flush, mid-stream reset and (with MEM_WB_PARITY_EN) the sticky parity error.
module tb_mem_wb_skid_stage;

   localparam int DATA_W     = 32;
   localparam int REG_ADDR_W = 5;

   logic                  clk = 1'b0;
   logic                  rst, flush;
   logic                  in_valid, in_ready, in_wb_en, in_mem_r_en;
   logic [DATA_W-1:0]     in_alu_res, in_mem_data;
   logic [REG_ADDR_W-1:0] in_dest;
   logic                  out_valid, out_ready, out_wb_en, fwd_valid, perr;
   logic [REG_ADDR_W-1:0] out_dest;
   logic [DATA_W-1:0]     out_wb_data;

   int nvec = 0;
   int nerr = 0;

   always #5 clk = ~clk;

   mem_wb_skid_stage #(.DATA_W(DATA_W), .REG_ADDR_W(REG_ADDR_W)) dut (
      .clk(clk), .rst(rst), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready), .in_wb_en(in_wb_en),
      .in_mem_r_en(in_mem_r_en), .in_alu_res(in_alu_res), .in_mem_data(in_mem_data),
      .in_dest(in_dest),
      .out_valid(out_valid), .out_ready(out_ready), .out_wb_en(out_wb_en),
      .out_dest(out_dest), .out_wb_data(out_wb_data), .fwd_valid(fwd_valid),
      .perr(perr)
   );

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      nvec++;
      if (got !== exp) begin
         nerr++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic drv(input logic v, input logic wb, input logic mr,
                      input logic [DATA_W-1:0] alu, input logic [DATA_W-1:0] mem,
                      input logic [REG_ADDR_W-1:0] dest);
      in_valid    = v;
      in_wb_en    = wb;
      in_mem_r_en = mr;
      in_alu_res  = alu;
      in_mem_data = mem;
      in_dest     = dest;
   endtask

   // inputs change and outputs are sampled on the falling edge
   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic idle();
      drv(1'b0, 1'b0, 1'b0, '0, '0, '0);
   endtask

`ifdef MEM_WB_PARITY_EN
   logic [$bits(dut.m_q)-1:0] bad_m;
`endif

   initial begin
      rst = 1'b1; flush = 1'b0; out_ready = 1'b0;
      idle();
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;

      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_wb_en", out_wb_en, 0);
      chk("rst_out_dest", out_dest, 0);
      chk("rst_out_wb_data", out_wb_data, 0);
      chk("rst_fwd_valid", fwd_valid, 0);
      chk("rst_in_ready", in_ready, 1);
      chk("rst_perr", perr, 0);

      // streaming at full rate
      out_ready = 1'b1;
      drv(1, 1, 0, 32'h11, 32'h0, 5'd3); step();
      chk("st0_data", out_wb_data, 32'h11);
      chk("st0_dest", out_dest, 3);
      chk("st0_in_ready", in_ready, 1);
      drv(1, 1, 0, 32'h22, 32'h0, 5'd4); step();
      chk("st1_data", out_wb_data, 32'h22);
      chk("st1_dest", out_dest, 4);
      chk("st1_in_ready", in_ready, 1);
      drv(1, 1, 0, 32'h33, 32'h0, 5'd5); step();
      chk("st2_data", out_wb_data, 32'h33);
      chk("st2_wb_en", out_wb_en, 1);
      chk("st2_in_ready", in_ready, 1);
      idle(); step();
      chk("st_drain_valid", out_valid, 0);
      chk("st_drain_wb_en", out_wb_en, 0);

      // backpressure fills the skid register
      out_ready = 1'b0;
      drv(1, 1, 0, 32'hA, 32'h0, 5'd7); step();
      chk("bp_a_data", out_wb_data, 32'hA);
      drv(1, 1, 0, 32'hB, 32'h0, 5'd8); step();
      chk("bp_skid_in_ready", in_ready, 0);
      chk("bp_skid_data", out_wb_data, 32'hA);
      chk("bp_skid_dest", out_dest, 7);
      // a push attempt while full must be refused
      drv(1, 1, 0, 32'hC, 32'h0, 5'd9); step();
      chk("bp_hold_data", out_wb_data, 32'hA);
      chk("bp_hold_in_ready", in_ready, 0);
      idle(); out_ready = 1'b1; step();
      chk("bp_pop_b_data", out_wb_data, 32'hB);
      chk("bp_pop_b_dest", out_dest, 8);
      chk("bp_pop_b_in_ready", in_ready, 1);
      step();
      chk("bp_empty_valid", out_valid, 0);

      // load select and dest-0 qualification
      out_ready = 1'b0;
      drv(1, 1, 1, 32'h100, 32'hDEADBEEF, 5'd9); step();
      chk("ld_data", out_wb_data, 32'hDEADBEEF);
      chk("ld_wb_en", out_wb_en, 1);
      chk("ld_fwd", fwd_valid, 1);
      out_ready = 1'b1;
      drv(1, 1, 1, 32'h100, 32'hDEADBEEF, 5'd0); step();
      chk("ld0_valid", out_valid, 1);
      chk("ld0_wb_en", out_wb_en, 0);
      chk("ld0_fwd", fwd_valid, 0);
      chk("ld0_data", out_wb_data, 32'hDEADBEEF);
      // full-width ALU value to the top register index
      drv(1, 1, 0, 32'hFFFFFFFF, 32'h5, 5'd31); step();
      chk("wide_data", out_wb_data, 32'hFFFFFFFF);
      chk("wide_dest", out_dest, 31);
      chk("wide_wb_en", out_wb_en, 1);
      idle(); step();

      // flush from SKID wins over pop and a same-cycle push
      out_ready = 1'b0;
      drv(1, 1, 0, 32'h1, 32'h0, 5'd1); step();
      drv(1, 1, 0, 32'h2, 32'h0, 5'd2); step();
      chk("fl_skid_in_ready", in_ready, 0);
      flush = 1'b1; out_ready = 1'b1;
      drv(1, 1, 0, 32'h3, 32'h0, 5'd3); step();
      flush = 1'b0; idle();
      chk("fl_valid", out_valid, 0);
      chk("fl_in_ready", in_ready, 1);
      chk("fl_wb_en", out_wb_en, 0);
      step();
      chk("fl_stays_empty", out_valid, 0);
      drv(1, 1, 0, 32'h44, 32'h0, 5'd6); step();
      chk("fl_after_data", out_wb_data, 32'h44);
      chk("fl_after_dest", out_dest, 6);
      idle(); step();

      // reset mid-stream with both registers occupied
      out_ready = 1'b0;
      drv(1, 1, 0, 32'h55, 32'h0, 5'd10); step();
      drv(1, 1, 0, 32'h66, 32'h0, 5'd11); step();
      rst = 1'b1; out_ready = 1'b1;
      drv(1, 1, 0, 32'h77, 32'h0, 5'd12); step();
      rst = 1'b0; idle();
      chk("mr_valid", out_valid, 0);
      chk("mr_in_ready", in_ready, 1);
      chk("mr_data", out_wb_data, 0);
      chk("mr_dest", out_dest, 0);
      chk("mr_perr", perr, 0);

`ifdef MEM_WB_PARITY_EN
      out_ready = 1'b0;
      drv(1, 1, 0, 32'h80, 32'h0, 5'd13); step();
      idle();
      chk("par_clean", perr, 0);
      bad_m = dut.m_q;
      bad_m[REG_ADDR_W + 1 + DATA_W] = ~bad_m[REG_ADDR_W + 1 + DATA_W];
      force dut.m_q = bad_m;
      step();
      chk("par_set", perr, 1);
      release dut.m_q;
      out_ready = 1'b1;
      drv(1, 1, 0, 32'h90, 32'h0, 5'd14); step();
      idle(); step(); step();
      chk("par_sticky", perr, 1);
      rst = 1'b1; step(); rst = 1'b0;
      chk("par_rst_clear", perr, 0);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
